mem_fill_arbiter: RTL and testbench
===================================

// Module: mem_fill_arbiter
// PURPOSE
//  Shares one pipelined main memory between the I-cache and D-cache miss paths.
//  Sequences 8-word block fills for the instruction-fetch and data requesters.
//  Also handles single-word data write-throughs.
//  Sits between the cache miss handlers and main memory; the pipeline stalls on i_req/d_req until the matching *_done.
// PARAMETERS
//  WORDS   8   words per block; power of two; byte offset width = log2(WORDS)+1
//  DATA_W  16  memory word width
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous, active-high reset
//  i_req          in   1   I-side fill request; held high until i_done
//  i_addr         in   16  I-side miss address; low log2(WORDS)+1 bits ignored
//  d_req          in   1   D-side request (fill or write); held high until d_done
//  d_wr           in   1   with d_req: 1=single-word write, 0=block fill
//  d_addr         in   16  D-side address (word address for write, miss address for fill)
//  d_wdata        in   16  D-side write data
//  i_grant        out  1   FSM in FILL_I
//  d_grant        out  1   FSM in FILL_D or WRITE
//  fill_data      out  16  returned word (mem_rdata passthrough)
//  fill_idx       out  3   word index of fill_data within block (return counter)
//  i_fill_valid   out  1   fill_data valid for I side
//  d_fill_valid   out  1   fill_data valid for D side
//  i_done         out  1   one-cycle pulse: last I fill word delivered
//  d_done         out  1   one-cycle pulse: last D fill word delivered or write issued
//  mem_addr       out  16  memory byte address
//  mem_enable     out  1   memory access strobe
//  mem_wr         out  1   memory write strobe
//  mem_wdata      out  16  memory write data
//  mem_rdata      in   16  memory read data
//  mem_rvalid     in   1   mem_rdata valid; memory is reset by the same rst
// BEHAVIOUR
//  - States: IDLE, FILL_I, FILL_D, WRITE; state, counters, base address and last_srv are registered.
//  - Reset: state=IDLE, issue_cnt=0, ret_cnt=0, last_srv=I. All outputs 0; fill_data passes mem_rdata.
//  - IDLE, one requester: go to FILL_I / FILL_D / WRITE (per d_wr) next cycle.
//    On the same edge: latch base={addr[15:4],4'h0} (fill) or d_addr/d_wdata (write); clear both counters.
//  - IDLE, both requesting: grant the side != last_srv (alternation, no starvation). last_srv is updated on grant.
//  - FILL_*: mem_enable=1, mem_wr=0, mem_addr=base+{issue_cnt,1'b0} for WORDS consecutive cycles (issue_cnt 0..WORDS-1).
//    No enable after issue_cnt saturates.
//  - FILL_*: each mem_rvalid asserts the granted side's *_fill_valid with fill_idx=ret_cnt, then ret_cnt++.
//  - FILL_*: return on ret_cnt==WORDS-1 with mem_rvalid pulses *_done in the same cycle; next state IDLE.
//  - WRITE: exactly 1 cycle: mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1; next state IDLE.
//  - Latency: request seen in cycle N -> first mem_enable in N+1. Fill done = N+1+mem_latency+WORDS-1.
//  - A request dropped mid-operation is ignored; the operation completes.
//    The same requester re-asserting in the cycle after done is re-granted (if the other side is idle).
//  - mem_rvalid in IDLE or WRITE is ignored; never raises *_fill_valid.
//  - rst mid-fill: immediate return to IDLE next edge, counters cleared, no *_done emitted.
//  - Address wrap: base+offset computed mod 2^16 (block at 16'hFFF0 issues up to 16'hFFFE).
// TESTING
//  - I-only fill, i_addr=16'h1236, 4-cycle memory:
//    mem_addr 1230,1232..123E on 8 consecutive cycles; i_fill_valid idx 0..7; i_done with idx 7.
//  - d_req&d_wr=1, d_addr=16'h0040, d_wdata=16'hBEEF:
//    one cycle mem_enable=mem_wr=1 at 0040/BEEF, d_done same cycle, back to IDLE.
//  - i_req and d_req (fill) rise together after reset:
//    D filled first (last_srv=I), then I. Two back-to-back D requests with I pending: I served between them.
//  - Assert rst during FILL_D after 3 returns: next cycle all outputs 0, no d_done.
//    A new d fill starts at idx 0.
//  - Inject mem_rvalid while IDLE: no fill_valid. Fill at 16'hFFF8: addresses FFF0..FFFE.

Source files
------------

// File: rtl/mem_fill_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_fill_arbiter_if : request, fill-return and memory bus bundle          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_fill_arbiter_if #(
  parameter int WORDS  = 8,
  parameter int DATA_W = 16
);
  localparam int IDX_W = $clog2(WORDS);

  logic              i_req;
  logic [15:0]       i_addr;
  logic              d_req;
  logic              d_wr;
  logic [15:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_grant;
  logic              d_grant;
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0]  fill_idx;
  logic              i_fill_valid;
  logic              d_fill_valid;
  logic              i_done;
  logic              d_done;
  logic [15:0]       mem_addr;
  logic              mem_enable;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_grant, d_grant, fill_data, fill_idx, i_fill_valid, d_fill_valid,
    output i_done, d_done, mem_addr, mem_enable, mem_wr, mem_wdata
  );

  // Requester / memory side
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_grant, d_grant, fill_data, fill_idx, i_fill_valid, d_fill_valid,
    input  i_done, d_done, mem_addr, mem_enable, mem_wr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_fill_arbiter : shares pipelined memory between I/D block fills       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_fill_arbiter #(
  parameter int WORDS  = 8,
  parameter int DATA_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mem_fill_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(WORDS);
  localparam int OFF_W = IDX_W + 1;
  localparam int CNT_W = IDX_W + 1;

  localparam logic [15:0] BASE_MASK = 16'hFFFF << OFF_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL_I = 2'd1;
  localparam logic [1:0] ST_FILL_D = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  localparam logic SRV_I = 1'b0;
  localparam logic SRV_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [15:0]       base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_srv_q, last_srv_d;

  logic              fill_active;
  logic              issue_now;
  logic              ret_now;
  logic              ret_last;
  logic              grant_i;
  logic              grant_d;
  logic [OFF_W-1:0]  word_off;

  always_comb begin
    fill_active = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);
    issue_now   = fill_active && (issue_cnt_q < CNT_W'(WORDS));
    ret_now     = fill_active && bus.mem_rvalid;
    ret_last    = ret_now && (ret_cnt_q == IDX_W'(WORDS - 1));
    word_off    = {issue_cnt_q[IDX_W-1:0], 1'b0};
    // On contention the side served last time yields, so neither side starves.
    grant_d     = bus.d_req && (!bus.i_req || (last_srv_q == SRV_I));
    grant_i     = bus.i_req && !grant_d;
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    last_srv_d  = last_srv_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_i || grant_d) begin
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end
        if (grant_i) begin
          state_d    = ST_FILL_I;
          base_d     = bus.i_addr & BASE_MASK;
          last_srv_d = SRV_I;
        end else if (grant_d) begin
          last_srv_d = SRV_D;
          if (bus.d_wr) begin
            state_d = ST_WRITE;
            base_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            state_d = ST_FILL_D;
            base_d  = bus.d_addr & BASE_MASK;
          end
        end
      end
      ST_FILL_I, ST_FILL_D: begin
        if (issue_now) issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (ret_now)   ret_cnt_d   = ret_cnt_q + IDX_W'(1);
        if (ret_last)  state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      last_srv_q  <= SRV_I;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      last_srv_q  <= last_srv_d;
    end
  end

  always_comb begin
    bus.i_grant      = (state_q == ST_FILL_I);
    bus.d_grant      = (state_q == ST_FILL_D) || (state_q == ST_WRITE);
    bus.fill_data    = bus.mem_rdata;
    bus.fill_idx     = ret_cnt_q;
    bus.i_fill_valid = (state_q == ST_FILL_I) && bus.mem_rvalid;
    bus.d_fill_valid = (state_q == ST_FILL_D) && bus.mem_rvalid;
    bus.i_done       = (state_q == ST_FILL_I) && ret_last;
    bus.d_done       = ((state_q == ST_FILL_D) && ret_last) || (state_q == ST_WRITE);
    bus.mem_enable   = issue_now || (state_q == ST_WRITE);
    bus.mem_wr       = (state_q == ST_WRITE);
    bus.mem_wdata    = (state_q == ST_WRITE) ? wdata_q : '0;
    // Offset add wraps mod 2^16 so the top block stays inside the address space.
    if (state_q == ST_WRITE)
      bus.mem_addr = base_q;
    else if (issue_now)
      bus.mem_addr = base_q + 16'(word_off);
    else
      bus.mem_addr = '0;
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_fill_arbiter : scoreboard bench with a 4-cycle pipelined memory   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_fill_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inject = 1'b0;
  always #5 clk = ~clk;

  mem_fill_arbiter_if #(.WORDS(8), .DATA_W(16)) bus ();

  mem_fill_arbiter #(.WORDS(8), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic        ig;
    logic        dg;
    logic        idn;
    logic        ddn;
  } mem_exp_t;

  typedef struct packed {
    logic        iv;
    logic        dv;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        idn;
    logic        ddn;
  } ret_exp_t;

  mem_exp_t mem_q[$];
  ret_exp_t ret_q[$];

  int checks = 0;
  int errors = 0;
  int i_done_cnt = 0;
  int d_done_cnt = 0;
  int d_ret_seen = 0;

  // Pipelined memory: read data returns LAT cycles after the enable cycle.
  logic [LAT-1:0] pv;
  logic [15:0]    pa [LAT];
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int k = 0; k < LAT; k++) pa[k] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], bus.mem_enable & ~bus.mem_wr};
      pa[0] <= bus.mem_addr;
      for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
    end
  end
  assign bus.mem_rvalid = pv[LAT-1] | inject;
  assign bus.mem_rdata  = pv[LAT-1] ? (pa[LAT-1] ^ 16'h5A5A) : (inject ? 16'hDEAD : 16'h0000);

  // Monitor: pops the scoreboard whenever the DUT presents an access or a return.
  mem_exp_t m_act, m_exp;
  ret_exp_t r_act, r_exp;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_enable) begin
        m_act = '{addr: bus.mem_addr, wr: bus.mem_wr, wdata: bus.mem_wdata,
                  ig: bus.i_grant, dg: bus.d_grant, idn: bus.i_done, ddn: bus.d_done};
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected got=%h (no access expected)", m_act);
        end else begin
          m_exp = mem_q.pop_front();
          if (m_act !== m_exp) begin
            errors++;
            $display("FAIL mem_access got=%h exp=%h", m_act, m_exp);
          end
        end
      end
      if (bus.i_fill_valid || bus.d_fill_valid) begin
        r_act = '{iv: bus.i_fill_valid, dv: bus.d_fill_valid, idx: bus.fill_idx,
                  data: bus.fill_data, idn: bus.i_done, ddn: bus.d_done};
        checks++;
        if (bus.d_fill_valid) d_ret_seen++;
        if (ret_q.size() == 0) begin
          errors++;
          $display("FAIL ret_unexpected got=%h (no return expected)", r_act);
        end else begin
          r_exp = ret_q.pop_front();
          if (r_act !== r_exp) begin
            errors++;
            $display("FAIL fill_return got=%h exp=%h", r_act, r_exp);
          end
        end
      end else if (!(bus.mem_enable && bus.mem_wr) && (bus.i_done || bus.d_done)) begin
        checks++;
        errors++;
        $display("FAIL stray_done i_done=%b d_done=%b exp=0", bus.i_done, bus.d_done);
      end
      if (bus.i_done) i_done_cnt++;
      if (bus.d_done) d_done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push_fill(input bit d_side, input logic [15:0] base);
    logic [15:0] a;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      mem_q.push_back('{addr: a, wr: 1'b0, wdata: 16'h0000, ig: !d_side, dg: d_side,
                        idn: 1'b0, ddn: 1'b0});
      ret_q.push_back('{iv: !d_side, dv: d_side, idx: 3'(k), data: a ^ 16'h5A5A,
                        idn: !d_side && (k == 7), ddn: d_side && (k == 7)});
    end
  endtask

  task automatic wait_done(input bit d_side, input string name);
    int start;
    int n;
    start = d_side ? d_done_cnt : i_done_cnt;
    for (n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if ((d_side ? d_done_cnt : i_done_cnt) != start) break;
    end
    checks++;
    if (n == 200) begin
      errors++;
      $display("FAIL %s timeout got=no_done exp=done", name);
    end
  endtask

  function automatic logic [63:0] out_flags();
    return {56'd0, bus.i_grant, bus.d_grant, bus.i_fill_valid, bus.d_fill_valid,
            bus.i_done, bus.d_done, bus.mem_enable, bus.mem_wr};
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int en_c, dn_c, n;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_wr = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", out_flags(), 64'd0);
    chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("reset_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("reset_fill_idx", 64'(bus.fill_idx), 64'd0);
    rst = 0;

    // rvalid while idle must not surface as a fill return
    @(posedge clk); #1 inject = 1;
    @(negedge clk);
    chk("idle_rvalid_flags", out_flags(), 64'd0);
    chk("idle_fill_data_pass", 64'(bus.fill_data), 64'hDEAD);
    @(posedge clk); #1 inject = 0;

    // simultaneous requests after reset: D first, then I
    push_fill(1'b1, 16'h2000);
    push_fill(1'b0, 16'h4A50);
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h2004;
    bus.i_req = 1; bus.i_addr = 16'h4A5E;
    wait_done(1'b1, "both_d_done");
    bus.d_req = 0;
    wait_done(1'b0, "both_i_done");
    bus.i_req = 0;

    // I-only fill with latency measurement from the request cycle
    push_fill(1'b0, 16'h1230);
    @(posedge clk); #1;
    bus.i_req = 1; bus.i_addr = 16'h1236;
    en_c = -1; dn_c = -1;
    for (int c = 0; c < 40 && dn_c < 0; c++) begin
      @(negedge clk);
      if (bus.mem_enable && en_c < 0) en_c = c;
      if (bus.i_done) dn_c = c;
    end
    chk("i_first_enable_cycle", 64'(en_c), 64'd1);
    chk("i_done_cycle", 64'(dn_c), 64'd12);
    @(posedge clk); #1 bus.i_req = 0;

    // single-word write-through
    mem_q.push_back('{addr: 16'h0040, wr: 1'b1, wdata: 16'hBEEF, ig: 1'b0, dg: 1'b1,
                      idn: 1'b0, ddn: 1'b1});
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0040; bus.d_wdata = 16'hBEEF;
    wait_done(1'b1, "write_done");
    bus.d_req = 0; bus.d_wr = 0; bus.d_wdata = '0;
    @(negedge clk);
    chk("write_then_idle", out_flags(), 64'd0);

    // back-to-back D with I pending: I is served between the two D fills
    push_fill(1'b1, 16'h3000);
    push_fill(1'b0, 16'h5000);
    push_fill(1'b1, 16'h3100);
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_addr = 16'h3008;
    for (n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.d_grant) break;
    end
    chk("b2b_d1_granted", 64'(bus.d_grant), 64'd1);
    bus.i_req = 1; bus.i_addr = 16'h5004;
    wait_done(1'b1, "b2b_d1_done");
    bus.d_addr = 16'h3104;
    wait_done(1'b0, "b2b_i_done");
    bus.i_req = 0;
    wait_done(1'b1, "b2b_d2_done");
    bus.d_req = 0;

    // top-of-memory block
    push_fill(1'b0, 16'hFFF0);
    bus.i_req = 1; bus.i_addr = 16'hFFF8;
    wait_done(1'b0, "wrap_i_done");
    bus.i_req = 0;

    // reset after three D returns: no done, everything idle
    push_fill(1'b1, 16'h0500);
    d_ret_seen = 0;
    bus.d_req = 1; bus.d_addr = 16'h0507;
    for (n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (d_ret_seen >= 3) break;
    end
    chk("rst_three_returns_seen", 64'(d_ret_seen >= 3), 64'd1);
    rst = 1; bus.d_req = 0;
    mem_q.delete(); ret_q.delete();
    @(negedge clk);
    chk("rst_cycle_no_d_done", 64'(bus.d_done), 64'd0);
    @(posedge clk); #1;
    chk("rst_after_flags", out_flags(), 64'd0);
    chk("rst_after_addr_idx", {32'd0, bus.mem_addr, 13'd0, bus.fill_idx}, 64'd0);
    chk("rst_after_data", {32'd0, bus.fill_data, bus.mem_wdata}, 64'd0);
    @(posedge clk); #1 rst = 0;

    // fresh D fill restarts at index 0
    push_fill(1'b1, 16'h0300);
    bus.d_req = 1; bus.d_addr = 16'h030A;
    wait_done(1'b1, "post_rst_d_done");
    bus.d_req = 0;

    repeat (8) @(posedge clk);
    #1;
    chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
    chk("ret_q_drained", 64'(ret_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
